// File: rtl/traffic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : traffic_pkg
// | Description : Shared lamp/state encodings and default timing for the
// |               multi-phase traffic controller.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    PS_CLEAR  = 2'd0,
    PS_GREEN  = 2'd1,
    PS_YELLOW = 2'd2
  } phase_state_e;

  localparam logic [2:0] c_lamp_red    = 3'b100;
  localparam logic [2:0] c_lamp_yellow = 3'b010;
  localparam logic [2:0] c_lamp_green  = 3'b001;

  localparam int c_def_tick_div  = 50_000_000;
  localparam int c_def_green_min = 10;
  localparam int c_def_green_max = 30;
  localparam int c_def_yellow_t  = 3;
  localparam int c_def_clear_t   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : tick_timer
// | Description : Tick prescaler plus saturating dwell counter, both cleared
// |               on restart (state entry).
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tick_timer #(
  parameter int TICK_DIV = 4,
  parameter int DWELL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  output logic               tick,
  output logic [DWELL_W-1:0] dwell
);

  localparam int c_pw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);

  logic [c_pw-1:0]    r_presc;
  logic [DWELL_W-1:0] r_dwell;
  logic               w_tick;

  assign w_tick = (r_presc == c_last);

  // Dwell saturates so an indefinite rest green never wraps back below GREEN_MIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_dwell <= '0;
    end else if (restart) begin
      r_presc <= '0;
      r_dwell <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_dwell != '1) r_dwell <= r_dwell + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign tick  = w_tick;
  assign dwell = r_dwell;

endmodule
`default_nettype wire

// File: rtl/multi_phase_traffic_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : multi_phase_traffic_controller
// | Description : N-phase signal controller with rest-in-green highway phase,
// |               demand latching and round-robin phase service.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module multi_phase_traffic_controller
  import traffic_pkg::*;
#(
  parameter int N_PHASES   = 2,
  parameter int TICK_DIV   = c_def_tick_div,
  parameter int GREEN_MIN  = c_def_green_min,
  parameter int GREEN_MAX  = c_def_green_max,
  parameter int YELLOW_T   = c_def_yellow_t,
  parameter int CLEAR_T    = c_def_clear_t,
  parameter int REST_PHASE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PHASES-1:0]         sensor,
  output logic [3*N_PHASES-1:0]       lights,
  output logic [$clog2(N_PHASES)-1:0] active_phase,
  output logic [1:0]                  phase_state,
  output logic [N_PHASES-1:0]         demand
);

  localparam int c_aw = $clog2(N_PHASES);
  localparam int c_dw = $clog2(max3(GREEN_MAX, YELLOW_T, CLEAR_T) + 2);
  localparam int c_cw = c_dw + 1;
  localparam logic [c_aw-1:0] c_rest  = c_aw'(REST_PHASE);
  localparam logic [c_cw-1:0] c_gmin  = c_cw'(GREEN_MIN);
  localparam logic [c_cw-1:0] c_gmax  = c_cw'(GREEN_MAX);
  localparam logic [c_cw-1:0] c_yel   = c_cw'(YELLOW_T);
  localparam logic [c_cw-1:0] c_clr   = c_cw'(CLEAR_T);

  phase_state_e          r_state, w_state_nxt;
  logic [c_aw-1:0]       r_active, w_active_nxt;
  logic [N_PHASES-1:0]   r_demand, w_demand_nxt;
  logic [N_PHASES-1:0]   w_own_mask, w_green_mask, w_enter;
  logic [3*N_PHASES-1:0] r_lights, w_lights_nxt;
  logic                  w_tick, w_restart, w_own_sensor, w_other_demand;
  logic [c_dw-1:0]       w_dwell;
  logic [c_cw-1:0]       w_done;

  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .DWELL_W  (c_dw)
  ) u_tick_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .tick    (w_tick),
    .dwell   (w_dwell)
  );

  // Ticks completed once the current (terminal) tick is counted.
  assign w_done = {1'b0, w_dwell} + 1'b1;

  function automatic logic [c_aw-1:0] pick_next(input logic [c_aw-1:0] cur,
                                                input logic [N_PHASES-1:0] dem);
    logic [c_aw-1:0] sel;
    logic [c_aw-1:0] idx_v;
    logic            found;
    int              idx;
    sel   = c_rest;
    found = 1'b0;
    for (int k = 1; k <= N_PHASES; k++) begin
      idx = int'(cur) + k;
      if (idx >= N_PHASES) idx = idx - N_PHASES;
      idx_v = c_aw'(idx);
      if (!found && dem[idx_v]) begin
        sel   = idx_v;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_phase
    assign w_own_mask[gi]   = (r_active == c_aw'(gi));
    assign w_green_mask[gi] = w_own_mask[gi] && (r_state == PS_GREEN);
    assign w_enter[gi]      = (r_state != PS_GREEN) && (w_state_nxt == PS_GREEN) &&
                              (w_active_nxt == c_aw'(gi));
    assign w_lights_nxt[3*gi +: 3] =
        (w_active_nxt != c_aw'(gi)) ? c_lamp_red    :
        (w_state_nxt == PS_GREEN)   ? c_lamp_green  :
        (w_state_nxt == PS_YELLOW)  ? c_lamp_yellow : c_lamp_red;
  end

  assign w_own_sensor   = |(sensor & w_own_mask);
  assign w_other_demand = |(r_demand & ~w_own_mask);
  // Clear beats set when a phase enters green on the same edge.
  assign w_demand_nxt   = (r_demand | (sensor & ~w_green_mask)) & ~w_enter;
  assign w_restart      = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    if (w_tick) begin
      unique case (r_state)
        PS_CLEAR: begin
          if (w_done >= c_clr) begin
            w_state_nxt  = PS_GREEN;
            w_active_nxt = pick_next(r_active, r_demand);
          end
        end
        PS_GREEN: begin
          // The rest phase only yields when some other approach is waiting.
          if ((w_done >= c_gmin) && (!w_own_sensor || (w_done >= c_gmax)) &&
              ((r_active != c_rest) || w_other_demand))
            w_state_nxt = PS_YELLOW;
        end
        PS_YELLOW: begin
          if (w_done >= c_yel) w_state_nxt = PS_CLEAR;
        end
        default: w_state_nxt = PS_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PS_CLEAR;
      r_active <= c_rest;
      r_demand <= '0;
      r_lights <= {N_PHASES{c_lamp_red}};
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_demand <= w_demand_nxt;
      r_lights <= w_lights_nxt;
    end
  end

  assign lights       = r_lights;
  assign active_phase = r_active;
  assign phase_state  = r_state;
  assign demand       = r_demand;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_traffic_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : tb_multi_phase_traffic_controller
// | Description : Directed self-checking bench, 3 phases, 4-cycle tick.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_multi_phase_traffic_controller;

  localparam logic [8:0] c_all_red = 9'b100_100_100;
  localparam logic [8:0] c_g0      = 9'b100_100_001;
  localparam logic [8:0] c_y0      = 9'b100_100_010;
  localparam logic [8:0] c_g1      = 9'b100_001_100;
  localparam logic [8:0] c_y1      = 9'b100_010_100;
  localparam logic [8:0] c_g2      = 9'b001_100_100;
  localparam logic [8:0] c_y2      = 9'b010_100_100;

  logic       clk;
  logic       rst_n;
  logic [2:0] sensor;
  logic [8:0] lights;
  logic [1:0] active_phase;
  logic [1:0] phase_state;
  logic [2:0] demand;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  multi_phase_traffic_controller #(
    .N_PHASES   (3),
    .TICK_DIV   (4),
    .GREEN_MIN  (2),
    .GREEN_MAX  (5),
    .YELLOW_T   (1),
    .CLEAR_T    (1),
    .REST_PHASE (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor       (sensor),
    .lights       (lights),
    .active_phase (active_phase),
    .phase_state  (phase_state),
    .demand       (demand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-hot lamps, at most one non-red, and the non-red one matches active_phase/state.
  function automatic bit lamp_ok();
    logic [2:0] f;
    int         nr;
    bit         ok;
    ok = 1'b1;
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      f = lights[3*i +: 3];
      if (!$onehot(f)) ok = 1'b0;
      if (f != 3'b100) begin
        nr++;
        if (active_phase != 2'(i)) ok = 1'b0;
        if (phase_state == 2'd1 && f != 3'b001) ok = 1'b0;
        if (phase_state == 2'd2 && f != 3'b010) ok = 1'b0;
      end
    end
    if (phase_state == 2'd0 && nr != 0) ok = 1'b0;
    if (phase_state != 2'd0 && nr != 1) ok = 1'b0;
    return ok;
  endfunction

  task automatic tick();
    @(negedge clk);
    chk("lamp_invariant", 32'(lamp_ok()), 32'd1);
  endtask

  task automatic run_len(input logic [8:0] val, output int cnt);
    cnt = 0;
    while (lights === val && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sensor = 3'b000;
    tick();
    tick();
    chk("reset_lights", 32'(lights), 32'(c_all_red));
    chk("reset_state", 32'(phase_state), 32'd0);
    chk("reset_active", 32'(active_phase), 32'd0);
    chk("reset_demand", 32'(demand), 32'd0);

    // Release: 4 red cycles then rest green held.
    rst_n = 1'b1;
    run_len(c_all_red, n);
    chk("initial_clear_len", 32'(n), 32'd4);
    chk("first_green_p0", 32'(lights), 32'(c_g0));
    repeat (20) tick();
    chk("rest_hold_lights", 32'(lights), 32'(c_g0));
    chk("rest_hold_state", 32'(phase_state), 32'd1);
    chk("rest_hold_demand", 32'(demand), 32'd0);

    // Single-cycle pulse on phase 2 during a long rest green.
    sensor = 3'b100;
    tick();
    sensor = 3'b000;
    chk("pulse_demand2", 32'(demand), 32'b100);
    run_len(c_g0, n);
    chk("rest_tail_bounded", 32'(n >= 1 && n <= 4), 32'd1);
    chk("p0_yellow_state", 32'(phase_state), 32'd2);
    run_len(c_y0, n);
    chk("p0_yellow_len", 32'(n), 32'd4);
    run_len(c_all_red, n);
    chk("clear_len_a", 32'(n), 32'd4);
    chk("p2_green", 32'(lights), 32'(c_g2));
    chk("p2_demand_cleared", 32'(demand), 32'd0);
    run_len(c_g2, n);
    chk("p2_green_len_min", 32'(n), 32'd8);
    run_len(c_y2, n);
    chk("p2_yellow_len", 32'(n), 32'd4);
    run_len(c_all_red, n);
    chk("clear_len_b", 32'(n), 32'd4);
    chk("back_to_rest", 32'(lights), 32'(c_g0));
    chk("back_to_rest_active", 32'(active_phase), 32'd0);

    // Phases 1 and 2 call together at fresh rest green: serve 1, 2, then 0.
    sensor = 3'b110;
    tick();
    sensor = 3'b000;
    chk("dual_demand", 32'(demand), 32'b110);
    run_len(c_g0, n);
    chk("rest_min_green_len", 32'(n), 32'd7);
    run_len(c_y0, n);
    run_len(c_all_red, n);
    chk("order_first_p1", 32'(lights), 32'(c_g1));
    chk("order_p1_active", 32'(active_phase), 32'd1);
    chk("order_p1_demand", 32'(demand), 32'b100);
    run_len(c_g1, n);
    chk("order_p1_len", 32'(n), 32'd8);
    run_len(c_y1, n);
    run_len(c_all_red, n);
    chk("order_second_p2", 32'(lights), 32'(c_g2));
    run_len(c_g2, n);
    run_len(c_y2, n);
    run_len(c_all_red, n);
    chk("order_third_p0", 32'(lights), 32'(c_g0));

    // Phase 1 held high permanently: max-out after 20 cycles, demand re-latched.
    sensor = 3'b010;
    run_len(c_g0, n);
    chk("rest_yield_len", 32'(n), 32'd8);
    run_len(c_y0, n);
    run_len(c_all_red, n);
    chk("max_p1_green", 32'(lights), 32'(c_g1));
    chk("max_p1_demand_clr", 32'(demand), 32'd0);
    run_len(c_g1, n);
    chk("max_p1_green_len", 32'(n), 32'd20);
    run_len(c_y1, n);
    chk("max_p1_yellow_len", 32'(n), 32'd4);
    chk("max_demand_reset", 32'(demand), 32'b010);
    run_len(c_all_red, n);
    chk("max_p1_reserviced", 32'(lights), 32'(c_g1));

    // Drop phase 1, call phase 2, then reset during phase 2 yellow.
    sensor = 3'b100;
    tick();
    sensor = 3'b000;
    run_len(c_g1, n);
    chk("p1_gap_out_len", 32'(n), 32'd7);
    run_len(c_y1, n);
    run_len(c_all_red, n);
    run_len(c_g2, n);
    chk("pre_reset_yellow2", 32'(lights), 32'(c_y2));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lights", 32'(lights), 32'(c_all_red));
    chk("async_rst_state", 32'(phase_state), 32'd0);
    chk("async_rst_active", 32'(active_phase), 32'd0);
    chk("async_rst_demand", 32'(demand), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    run_len(c_all_red, n);
    chk("recover_clear_len", 32'(n), 32'd4);
    chk("recover_green_p0", 32'(lights), 32'(c_g0));
    chk("recover_demand", 32'(demand), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
